ahb_pipelined_master: RTL

AHB-Lite master for the edge-detection subsystem.
- Accepts single-word read/write commands from a local requester into a small command FIFO.
- Issues them on the bus with overlapped address and data phases, honouring hready wait states.
- Returns read data to the requester.
- Drives the configuration slave (image size, read/write start addresses, done status) and pixel memory.

---
 rtl/ahb_pipelined_master_if.sv | 52 +++++
 rtl/ahb_pipelined_master.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ahb_pipelined_master_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_pipelined_master_if
// Brief    : Requester and AHB-Lite bundle for ahb_pipelined_master.
//            AHB_MASTER_ERR_EN adds hresp and err_sticky.
// Revision : 1.0
// ============================================================================
interface ahb_pipelined_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [DATA_W-1:0] hwdata;
    logic [DATA_W-1:0] hrdata;
    logic              hready;
`ifdef AHB_MASTER_ERR_EN
    logic              hresp;
    logic              err_sticky;
`endif

    modport master (
        input  req, req_write, req_addr, req_wdata, hrdata, hready,
`ifdef AHB_MASTER_ERR_EN
        input  hresp,
        output err_sticky,
`endif
        output req_ready, rsp_valid, rsp_rdata, busy,
        output haddr, htrans, hwrite, hsize, hwdata
    );

    modport slave (
        output req, req_write, req_addr, req_wdata, hrdata, hready,
`ifdef AHB_MASTER_ERR_EN
        output hresp,
        input  err_sticky,
`endif
        input  req_ready, rsp_valid, rsp_rdata, busy,
        input  haddr, htrans, hwrite, hsize, hwdata
    );
endinterface
`default_nettype wire

// File: rtl/ahb_pipelined_master.sv
`default_nettype none
// ============================================================================
// Module   : ahb_pipelined_master
// Brief    : AHB-Lite single-word master, command FIFO + overlapped AP/DP.
//            Optional error handling under macro AHB_MASTER_ERR_EN.
// Revision : 1.0
// ============================================================================
module ahb_pipelined_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  wire logic              clk,
    input  wire logic              n_rst,
    ahb_pipelined_master_if.master bus
);
    localparam int                 c_ptr_w  = $clog2(FIFO_DEPTH);
    localparam logic [c_ptr_w:0]   c_depth  = (c_ptr_w+1)'(FIFO_DEPTH);
    localparam logic [1:0]         c_idle   = 2'b00;
    localparam logic [1:0]         c_nonseq = 2'b10;

    logic [ADDR_W-1:0]  r_fifo_addr  [FIFO_DEPTH];
    logic [DATA_W-1:0]  r_fifo_wdata [FIFO_DEPTH];
    logic               r_fifo_write [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;

    logic               r_ap_valid;
    logic               r_ap_write;
    logic [ADDR_W-1:0]  r_ap_addr;
    logic [DATA_W-1:0]  r_ap_wdata;
    logic               r_dp_valid;
    logic               r_dp_write;
    logic [DATA_W-1:0]  r_dp_wdata;
    logic               r_dp_err;
    logic               r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_rdata;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_err;

    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);
    assign w_push  = bus.req & ~w_full;
    assign w_pop   = bus.hready & ~w_empty;

`ifdef AHB_MASTER_ERR_EN
    logic r_err_sticky;

    // First cycle of the two-cycle ERROR response: hready still low.
    assign w_err = r_dp_valid & bus.hresp & ~bus.hready;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_err_sticky <= 1'b0;
        end else if (w_err) begin
            r_err_sticky <= 1'b1;
        end
    end

    assign bus.err_sticky = r_err_sticky;
`else
    assign w_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr]  <= bus.req_addr;
            r_fifo_wdata[r_wr_ptr] <= bus.req_wdata;
            r_fifo_write[r_wr_ptr] <= bus.req_write;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_ap_valid  <= 1'b0;
            r_ap_write  <= 1'b0;
            r_ap_addr   <= '0;
            r_ap_wdata  <= '0;
            r_dp_valid  <= 1'b0;
            r_dp_write  <= 1'b0;
            r_dp_wdata  <= '0;
            r_dp_err    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (bus.hready) begin
                r_dp_valid <= r_ap_valid;
                r_dp_write <= r_ap_write;
                r_dp_wdata <= r_ap_wdata;
                r_dp_err   <= 1'b0;
                if (r_dp_valid && !r_dp_write && !r_dp_err) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= bus.hrdata;
                end
                // haddr/hwrite keep their last values while the bus idles.
                if (!w_empty) begin
                    r_ap_valid <= 1'b1;
                    r_ap_write <= r_fifo_write[r_rd_ptr];
                    r_ap_addr  <= r_fifo_addr[r_rd_ptr];
                    r_ap_wdata <= r_fifo_wdata[r_rd_ptr];
                end else begin
                    r_ap_valid <= 1'b0;
                end
            end else if (w_err) begin
                r_ap_valid <= 1'b0;
                r_dp_err   <= 1'b1;
            end
        end
    end

    assign bus.req_ready = ~w_full;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.busy      = ~w_empty | r_ap_valid | r_dp_valid;
    assign bus.haddr     = r_ap_addr;
    assign bus.htrans    = r_ap_valid ? c_nonseq : c_idle;
    assign bus.hwrite    = r_ap_write;
    assign bus.hsize     = 3'b010;
    assign bus.hwdata    = r_dp_wdata;
endmodule
`default_nettype wire
